pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// mul/div stall FSM encoding and the default mul/div latency.
package pipe_hazard_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EXE = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_LD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  localparam int MD_CYCLES_DEF = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forward select for one source register; EX result beats MEM, and
// register 0 is never forwarded.
module pipe_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  output fwd_sel_t   sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ewreg & (ern != 5'd0) & (ern == src);
  assign mem_hit = mwreg & (mrn != 5'd0) & (mrn == src);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !em2reg)
      sel = FWD_EXE;
    else if (mem_hit && !mm2reg)
      sel = FWD_MEM;
    else if (mem_hit && mm2reg)
      sel = FWD_LD;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, multi-cycle
// mul/div stall and branch flush gating.
//
// state | meaning
// IDLE  | no mul/div in flight; md_start in ID triggers the stall
// BUSY  | mul/div running, ID held, cnt counts down to 0
// DONE  | last cycle of the mul/div; stall released, md_start ignored
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  input  logic       branch_taken,
  input  logic       md_start,
  output logic       wpc,
  output logic       wpcir,
  output logic       bubble,
  output logic       flush,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       md_busy
);

  // The trigger cycle already counts as one stall cycle, so BUSY lasts
  // MD_CYCLES-1 cycles: cnt runs from MD_CYCLES-2 down to 0.
  localparam logic [4:0] CNT_LOAD = 5'(MD_CYCLES - 2);

  md_state_t  state;
  logic [4:0] cnt;
  logic       lu;
  logic       md_trig;
  logic       stall;

  pipe_fwd_sel u_fwd_rs (
    .src    (rs),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .ern    (ern),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mrn    (mrn),
    .sel    (fwda)
  );

  pipe_fwd_sel u_fwd_rt (
    .src    (rt),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .ern    (ern),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mrn    (mrn),
    .sel    (fwdb)
  );

  assign lu = ewreg & em2reg & (ern != 5'd0) &
              ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

  assign md_trig = (state == ST_IDLE) & md_start;
  assign stall   = lu | (state == ST_BUSY) | md_trig;

  assign wpc     = ~stall;
  assign wpcir   = ~stall;
  assign bubble  = stall;
  assign flush   = branch_taken & ~stall;
  assign md_busy = (state != ST_IDLE);

  // A load-use hazard on the mul/div itself postpones the trigger by a cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_start && !lu) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt == 5'd0)
            state <= ST_DONE;
          else
            cnt <= cnt - 5'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with an expected-output queue.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] rs, rt, ern, mrn;
  logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
  logic       branch_taken, md_start;
  logic       wpc, wpcir, bubble, flush, md_busy;
  logic [1:0] fwda, fwdb;

  logic [8:0] exp_q[$];
  int         passed = 0;
  int         total  = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MD_CYCLES(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .rs           (rs),
    .rt           (rt),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .ewreg        (ewreg),
    .em2reg       (em2reg),
    .ern          (ern),
    .mwreg        (mwreg),
    .mm2reg       (mm2reg),
    .mrn          (mrn),
    .branch_taken (branch_taken),
    .md_start     (md_start),
    .wpc          (wpc),
    .wpcir        (wpcir),
    .bubble       (bubble),
    .flush        (flush),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .md_busy      (md_busy)
  );

  task automatic idle_inputs();
    rs = 5'd0; rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
    mwreg = 1'b0; mm2reg = 1'b0; mrn = 5'd0;
    branch_taken = 1'b0; md_start = 1'b0;
  endtask

  // Expected word layout: {wpc, wpcir, bubble, flush, fwda, fwdb, md_busy}
  task automatic expect_out(input logic e_wpc, input logic e_wpcir, input logic e_bubble,
                            input logic e_flush, input logic [1:0] e_fwda,
                            input logic [1:0] e_fwdb, input logic e_busy);
    exp_q.push_back({e_wpc, e_wpcir, e_bubble, e_flush, e_fwda, e_fwdb, e_busy});
  endtask

  task automatic check(input string tag);
    logic [8:0] obs;
    logic [8:0] exp_v;
    obs = {wpc, wpcir, bubble, flush, fwda, fwdb, md_busy};
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %b but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clock);
    check(tag);
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // Reset with idle inputs: pipeline free-running, nothing forwarded.
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("reset_idle");
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("reset_held");
    resetn = 1'b1;

    // EX beats MEM on the same register.
    ewreg = 1; em2reg = 0; ern = 5'd5; rs = 5'd5; use_rs = 1;
    mwreg = 1; mm2reg = 0; mrn = 5'd5;
    expect_out(1, 1, 0, 0, 2'b01, 2'b00, 0);
    cycle("fwd_ex_priority");

    // MEM ALU result to both operands.
    idle_inputs();
    mwreg = 1; mm2reg = 0; mrn = 5'd7; rs = 5'd7; rt = 5'd7;
    expect_out(1, 1, 0, 0, 2'b10, 2'b10, 0);
    cycle("fwd_mem_both");

    // MEM load data to rt only.
    idle_inputs();
    mwreg = 1; mm2reg = 1; mrn = 5'd9; rt = 5'd9; rs = 5'd3;
    expect_out(1, 1, 0, 0, 2'b00, 2'b11, 0);
    cycle("fwd_ld_rt");

    // Load-use on rt; a coincident branch must not flush.
    idle_inputs();
    ewreg = 1; em2reg = 1; ern = 5'd8; rt = 5'd8; use_rt = 1; branch_taken = 1;
    expect_out(0, 0, 1, 0, 2'b00, 2'b00, 0);
    cycle("load_use_stall");

    // Load moved to MEM: forward load data, stall released, branch now flushes.
    idle_inputs();
    mwreg = 1; mm2reg = 1; mrn = 5'd8; rt = 5'd8; use_rt = 1; branch_taken = 1;
    expect_out(1, 1, 0, 1, 2'b00, 2'b11, 0);
    cycle("load_use_release");

    // Load to $0 never stalls nor forwards.
    idle_inputs();
    ewreg = 1; em2reg = 1; ern = 5'd0; rs = 5'd0; use_rs = 1;
    mwreg = 1; mm2reg = 0; mrn = 5'd0;
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("reg0_no_stall");

    // Matching load but the operand is not actually read: no stall.
    idle_inputs();
    ewreg = 1; em2reg = 1; ern = 5'd12; rs = 5'd12; use_rs = 0;
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("unused_src_no_stall");

    // md_start blocked by load-use: stall from lu, FSM must stay IDLE.
    idle_inputs();
    ewreg = 1; em2reg = 1; ern = 5'd4; rs = 5'd4; use_rs = 1; md_start = 1;
    expect_out(0, 0, 1, 0, 2'b00, 2'b00, 0);
    cycle("md_blocked_by_lu");
    idle_inputs();
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("md_not_started");

    // Full mul/div stall, MD_CYCLES = 8.
    idle_inputs();
    md_start = 1;
    expect_out(0, 0, 1, 0, 2'b00, 2'b00, 0);
    cycle("md_trigger");
    for (int i = 1; i <= 7; i++) begin
      branch_taken = (i == 3);
      expect_out(0, 0, 1, 0, 2'b00, 2'b00, 1);
      cycle($sformatf("md_busy_%0d", i));
    end
    branch_taken = 1;
    expect_out(1, 1, 0, 1, 2'b00, 2'b00, 1);
    cycle("md_done_flush");
    idle_inputs();
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("md_back_idle");

    // Reset mid-BUSY at cnt=3 abandons the operation.
    md_start = 1;
    expect_out(0, 0, 1, 0, 2'b00, 2'b00, 0);
    cycle("md2_trigger");
    for (int i = 1; i <= 3; i++) begin
      expect_out(0, 0, 1, 0, 2'b00, 2'b00, 1);
      cycle($sformatf("md2_busy_%0d", i));
    end
    md_start = 0;
    resetn = 1'b0;
    #1;
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    check("reset_mid_busy");
    #2;
    resetn = 1'b1;
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("post_reset_idle_1");
    expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0);
    cycle("post_reset_idle_2");

    if (exp_q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
